// File: rtl/tomasulo_pkg.sv
// Definitions shared by the Tomasulo reservation stations and functional units.
package tomasulo_pkg;

    localparam int unsigned RS_TAG_W   = 3;
    localparam int unsigned CDB_DATA_W = 16;

    // Tag 0 marks an operand with no pending producer; never issued to a unit.
    localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

    typedef enum logic {
        OP_MUL  = 1'b0,
        OP_MULH = 1'b1
    } op_e;

endpackage

// File: rtl/mult_functional_unit_if.sv
// Issue and CDB handshake between the multiplier stations, the unit and the CDB arbiter.
interface mult_functional_unit_if
    import tomasulo_pkg::*;
#(
    parameter int unsigned DATA_W = CDB_DATA_W,
    parameter int unsigned TAG_W  = RS_TAG_W
);

    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_tag;
    logic              issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic              cdb_req;
    logic              cdb_grant;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              busy;

    modport master (
        output issue_valid, issue_tag, issue_op, issue_vj, issue_vk, cdb_grant,
        input  issue_ready, cdb_req, cdb_tag, cdb_data, busy
    );

    modport slave (
        input  issue_valid, issue_tag, issue_op, issue_vj, issue_vk, cdb_grant,
        output issue_ready, cdb_req, cdb_tag, cdb_data, busy
    );

endinterface

// File: rtl/cdb_out_buffer.sv
// Result FIFO in front of the CDB; head stays visible (last popped value) when empty.
module cdb_out_buffer #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] last_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = empty ? last_q : mem[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
                last_q   <= mem[rd_ptr_q];
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: it is only observed while the count says it is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mult_functional_unit.sv
// Fixed-latency multiply unit: issue -> LATENCY-stage pipeline -> result FIFO -> CDB request.
module mult_functional_unit
    import tomasulo_pkg::*;
#(
    parameter int unsigned DATA_W   = CDB_DATA_W,
    parameter int unsigned TAG_W    = RS_TAG_W,
    parameter int unsigned LATENCY  = 3,
    parameter int unsigned OB_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    mult_functional_unit_if.slave  bus
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic              st_valid_q [LATENCY];
    logic [TAG_W-1:0]  st_tag_q   [LATENCY];
    op_e               st_op_q    [LATENCY];
    logic [PROD_W-1:0] st_prod_q  [LATENCY];

    logic                    stall, push, pop, ob_full, ob_empty, busy_c;
    logic [PROD_W-1:0]       product;
    logic [DATA_W-1:0]       result;
    logic [TAG_W+DATA_W-1:0] head;

    assign product = {{DATA_W{1'b0}}, bus.issue_vj} * {{DATA_W{1'b0}}, bus.issue_vk};

    always_comb begin
        pop    = !ob_empty && bus.cdb_grant;
        // A full buffer only blocks the final stage if nothing drains this cycle.
        stall  = st_valid_q[LATENCY-1] && ob_full && !pop;
        push   = st_valid_q[LATENCY-1] && !stall;
        result = (st_op_q[LATENCY-1] == OP_MULH) ? st_prod_q[LATENCY-1][PROD_W-1:DATA_W]
                                                 : st_prod_q[LATENCY-1][DATA_W-1:0];
        busy_c = !ob_empty;
        for (int i = 0; i < LATENCY; i++) busy_c = busy_c | st_valid_q[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                st_valid_q[i] <= 1'b0;
                st_tag_q[i]   <= '0;
                st_op_q[i]    <= OP_MUL;
                st_prod_q[i]  <= '0;
            end
        end else if (!stall) begin
            st_valid_q[0] <= bus.issue_valid;
            st_tag_q[0]   <= bus.issue_tag;
            st_op_q[0]    <= op_e'(bus.issue_op);
            st_prod_q[0]  <= product;
            for (int i = 1; i < LATENCY; i++) begin
                st_valid_q[i] <= st_valid_q[i-1];
                st_tag_q[i]   <= st_tag_q[i-1];
                st_op_q[i]    <= st_op_q[i-1];
                st_prod_q[i]  <= st_prod_q[i-1];
            end
        end
    end

    cdb_out_buffer #(
        .WIDTH (TAG_W + DATA_W),
        .DEPTH (OB_DEPTH)
    ) u_ob (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({st_tag_q[LATENCY-1], result}),
        .full  (ob_full),
        .empty (ob_empty),
        .rdata (head)
    );

    assign bus.issue_ready = !stall;
    assign bus.cdb_req     = !ob_empty;
    assign bus.cdb_tag     = head[TAG_W+DATA_W-1:DATA_W];
    assign bus.cdb_data    = head[DATA_W-1:0];
    assign bus.busy        = busy_c;

endmodule

// File: tb/tb_mult_functional_unit.sv
// Directed + random bench for mult_functional_unit against a queue-based reference model.
module tb_mult_functional_unit;

    localparam int LAT = 3;
    localparam int OB  = 2;

    typedef struct {
        bit        v;
        bit [2:0]  tag;
        bit [15:0] res;
    } ent_t;

    typedef struct {
        bit [2:0]  tag;
        bit [15:0] res;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mult_functional_unit_if intf ();

    mult_functional_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    always #5 clk = ~clk;

    ent_t      pipe [LAT];
    res_t      obq [$];
    bit [2:0]  last_tag;
    bit [15:0] last_data;
    int        checks   = 0;
    int        failures = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h, expected %0h", name, obs, exp);
        end
    endtask

    function automatic bit [15:0] ref_result(input bit op, input bit [15:0] a, input bit [15:0] b);
        bit [31:0] p;
        p = 32'(a) * 32'(b);
        return op ? p[31:16] : p[15:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LAT; i++) pipe[i].v = 1'b0;
        obq.delete();
        last_tag  = '0;
        last_data = '0;
    endtask

    // One clock: drive, check outputs against model, advance model across the edge.
    task automatic step(input bit v, input bit [2:0] tag, input bit op, input bit [15:0] a,
                        input bit [15:0] b, input bit g, output bit acc);
        bit        m_req, m_pop, m_stall, m_busy;
        bit [2:0]  et;
        bit [15:0] ed;
        res_t      r;
        intf.issue_valid = v;
        intf.issue_tag   = tag;
        intf.issue_op    = op;
        intf.issue_vj    = a;
        intf.issue_vk    = b;
        intf.cdb_grant   = g;
        #1;
        m_req   = obq.size() != 0;
        m_pop   = m_req && g;
        m_stall = pipe[LAT-1].v && (obq.size() == OB) && !m_pop;
        m_busy  = m_req;
        for (int i = 0; i < LAT; i++) m_busy = m_busy | pipe[i].v;
        et = m_req ? obq[0].tag : last_tag;
        ed = m_req ? obq[0].res : last_data;
        check("issue_ready", intf.issue_ready, !m_stall);
        check("cdb_req", intf.cdb_req, m_req);
        check("cdb_tag", intf.cdb_tag, et);
        check("cdb_data", intf.cdb_data, ed);
        check("busy", intf.busy, m_busy);
        acc = v && intf.issue_ready;
        @(posedge clk);
        if (m_pop) begin
            last_tag  = obq[0].tag;
            last_data = obq[0].res;
            void'(obq.pop_front());
        end
        if (!m_stall) begin
            if (pipe[LAT-1].v) begin
                r.tag = pipe[LAT-1].tag;
                r.res = pipe[LAT-1].res;
                obq.push_back(r);
            end
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0].v   = v;
            pipe[0].tag = tag;
            pipe[0].res = ref_result(op, a, b);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, intf.issue_ready, 1);
        check({name, "_req"}, intf.cdb_req, 0);
        check({name, "_tag"}, intf.cdb_tag, 0);
        check({name, "_data"}, intf.cdb_data, 0);
        check({name, "_busy"}, intf.busy, 0);
    endtask

    task automatic idle(input bit g);
        bit acc;
        step(1'b0, 3'd0, 1'b0, 16'h0, 16'h0, g, acc);
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!intf.cdb_req && n < 10) begin
            idle(1'b0);
            n++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (intf.busy && n < 20) begin
            idle(1'b1);
            n++;
        end
        check("drain_busy", intf.busy, 0);
    endtask

    initial begin
        bit acc;
        int n, nacc, t;
        intf.issue_valid = 1'b0;
        intf.issue_tag   = '0;
        intf.issue_op    = 1'b0;
        intf.issue_vj    = '0;
        intf.issue_vk    = '0;
        intf.cdb_grant   = 1'b0;
        model_clear();
        @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Single MUL, latency to request
        step(1'b1, 3'd1, 1'b0, 16'd3, 16'd5, 1'b1, acc);
        check("t1_acc", acc, 1);
        wait_req(n);
        check("t1_latency", n, 3);
        check("t1_tag", intf.cdb_tag, 1);
        check("t1_data", intf.cdb_data, 16'h000F);
        idle(1'b1);
        check("t1_req_drop", intf.cdb_req, 0);

        // Back-to-back MULH then MUL, in-order broadcast
        step(1'b1, 3'd2, 1'b1, 16'h1234, 16'h0100, 1'b1, acc);
        step(1'b1, 3'd3, 1'b0, 16'h1234, 16'h0100, 1'b1, acc);
        wait_req(n);
        check("t2_tag_a", intf.cdb_tag, 2);
        check("t2_data_a", intf.cdb_data, 16'h0012);
        idle(1'b1);
        check("t2_req_b", intf.cdb_req, 1);
        check("t2_tag_b", intf.cdb_tag, 3);
        check("t2_data_b", intf.cdb_data, 16'h3400);
        idle(1'b1);
        check("t2_req_end", intf.cdb_req, 0);

        // Capacity under withheld grant, then a single-cycle grant with push+pop
        t = 1;
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'(t), 1'b0, 16'(t), 16'd7, 1'b0, acc);
            if (acc) begin
                nacc++;
                if (t < 6) t++;
            end
        end
        check("t3_accepted", nacc, 5);
        check("t3_ready_low", intf.issue_ready, 0);
        check("t3_head", intf.cdb_tag, 1);
        step(1'b1, 3'd6, 1'b0, 16'd6, 16'd7, 1'b1, acc);
        check("t3_tag6_acc", acc, 1);
        intf.cdb_grant = 1'b0;
        #1;
        check("t3_restall", intf.issue_ready, 0);
        check("t3_head2", intf.cdb_tag, 2);
        check("t3_full_req", intf.cdb_req, 1);
        drain();

        // Asynchronous reset with operations in flight
        for (int i = 1; i <= 3; i++) step(1'b1, 3'(i), 1'b0, 16'(i), 16'd9, 1'b0, acc);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("t4_no_bcast", intf.cdb_req, 0);

        // Extreme operands, then grant with nothing to send
        step(1'b1, 3'd1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, acc);
        step(1'b1, 3'd2, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, acc);
        wait_req(n);
        check("t5_mul", intf.cdb_data, 16'h0001);
        idle(1'b1);
        check("t5_mulh", intf.cdb_data, 16'hFFFE);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("t5_idle_req", intf.cdb_req, 0);
        check("t5_idle_tag", intf.cdb_tag, 2);
        check("t5_idle_data", intf.cdb_data, 16'hFFFE);
        check("t5_idle_busy", intf.busy, 0);

        // Random traffic with bursty grant
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom), $urandom_range(0, 2) != 0, acc);
        end
        drain();
        check("rand_model_empty", obq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_functional_unit.md
Name: mult_functional_unit

Overview:
- Multiply functional unit that sits directly downstream of the multiplier reservation stations in the Tomasulo datapath.
- Accepts one dispatched operation per cycle: station tag, opcode and both ready operands (Vj, Vk).
- Computes in a fixed-latency pipeline, buffers finished results, and requests the CDB to broadcast the (tag, value) pair.
- Back-pressures the stations when results cannot drain because the CDB arbiter withholds grant.

Parameters:
- DATA_W, 16: operand and CDB data width.
- TAG_W, 3: reservation-station tag width; tag 0 is reserved for "no producer" and is never issued.
- LATENCY, 3: pipeline stages from issue to result-buffer write; must be >= 1.
- OB_DEPTH, 2: result output buffer depth; power of two.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  station presents an operation.
- issue_ready  out  1  unit can accept this cycle.
- issue_tag  in  TAG_W  tag of the issuing station.
- issue_op  in  1  0 = MUL (low half of product), 1 = MULH (high half, unsigned).
- issue_vj  in  DATA_W  operand j.
- issue_vk  in  DATA_W  operand k.
- cdb_req  out  1  buffer holds a result awaiting broadcast.
- cdb_grant  in  1  arbiter grants the CDB this cycle.
- cdb_tag  out  TAG_W  tag of the head result.
- cdb_data  out  DATA_W  value of the head result.
- busy  out  1  any pipeline stage or buffer entry is valid.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-operation):
  - Clears all stage valid bits and buffer pointers/count.
  - Outputs: issue_ready=1, cdb_req=0, cdb_tag=0, cdb_data=0, busy=0.
  - In-flight operations are discarded; nothing is broadcast for them.
- Accept: an operation is captured on a rising edge where issue_valid && issue_ready. Inputs are ignored otherwise.
- Stage 0 registers tag, op, valid and the full 2*DATA_W-bit unsigned product vj*vk.
- Stages 1..LATENCY-1 shift tag/op/product forward.
- At the final stage, op selects the half written to the buffer: product[DATA_W-1:0] for MUL, product[2*DATA_W-1:DATA_W] for MULH.
- Latency: an operation accepted at edge k is written to the buffer at edge k+LATENCY. With an empty buffer, cdb_req is high and cdb_tag/cdb_data are valid in the cycle following that edge.
- Stall:
  - stall = last_stage_valid && buffer_full && !(cdb_req && cdb_grant).
  - While stalled, the entire pipeline holds and issue_ready=0 (combinational from stall).
  - Bubbles are not compressed.
- Output buffer:
  - FIFO; cdb_req = !empty; cdb_tag/cdb_data driven from the head entry.
  - On cdb_req && cdb_grant the head is popped at the edge.
  - Simultaneous push and pop when full is legal: count unchanged, no stall.
  - Pointers wrap modulo OB_DEPTH.
- cdb_grant while cdb_req=0 is ignored; no pop, no state change.
- When empty, cdb_tag/cdb_data hold their last value; consumers qualify with cdb_req.
- Ordering: results broadcast in issue order.
- Capacity: LATENCY + OB_DEPTH operations in flight (5 with defaults).
- busy = OR of all stage valid bits and !empty.

Decomposition:
- Shared package tomasulo_pkg, common to stations and functional units:
  - OP_MUL=1'b0, OP_MULH=1'b1.
  - TAG_W, DATA_W defaults.
  - TAG_NONE=0.
- Sub-module cdb_out_buffer: parameterised FIFO with push/pop, full/empty and head outputs. Reused later by the adder unit.

Test Plan:
- Reset, issue tag 1, MUL, vj=3, vk=5, grant tied high → cdb_req rises 3 cycles after issue with cdb_tag=1, cdb_data=0x000F; next cycle cdb_req=0.
- Issue tag 2, MULH, 0x1234*0x0100, then tag 3, MUL, same operands back-to-back → broadcasts tag 2 = 0x0012, then tag 3 = 0x3400, in order on consecutive cycles.
- Grant held 0, issue_valid held high with tags 1..6 → exactly 5 accepted, issue_ready=0 thereafter. Release grant for one cycle → tag 1 broadcast, tag 6 accepted the same edge.
- Buffer full and final stage valid, grant pulsed for one cycle → pop and push on the same edge, count stays 2, issue_ready stays 1 that cycle.
- Assert Reset with 3 operations in flight → all outputs at reset values immediately (asynchronous), no broadcast after deassertion.
- Edge operands: 0xFFFF*0xFFFF → MUL gives 0x0001, MULH gives 0xFFFE; grant with cdb_req=0 → no state change.
